bram_port_arbiter: RTL and testbench

- Sequences and shares one single-port 32-bit BRAM between two requesters: the management Wishbone slave (CPU) and the UART DMA engine inside the uart/bram user project.
- Round-robin arbitration with a fixed-latency access FSM.
- Generates Wishbone acks and DMA grant/read-valid strobes.
- Sits between the Wishbone slave interface and the BRAM macro.

---
 rtl/bram_port_arbiter_if.sv | 47 ++++
 rtl/bram_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Boundary bundle of bram_port_arbiter: Wishbone slave, DMA command port, BRAM macro port and grant statistics.
interface bram_port_arbiter_if #(
  parameter int ADR_W = 10
);
  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_adr_i;
  logic [31:0]      wbs_dat_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic             dma_req_i;
  logic             dma_we_i;
  logic [ADR_W-1:0] dma_adr_i;
  logic [31:0]      dma_dat_i;
  logic             dma_gnt_o;
  logic             dma_rvalid_o;
  logic [31:0]      dma_rdata_o;
  logic             bram_en_o;
  logic [3:0]       bram_we_o;
  logic [ADR_W-1:0] bram_adr_o;
  logic [31:0]      bram_wdata_o;
  logic [31:0]      bram_rdata_i;
  logic [15:0]      stat_wb_cnt_o;
  logic [15:0]      stat_dma_cnt_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  dma_req_i, dma_we_i, dma_adr_i, dma_dat_i,
    output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    output bram_en_o, bram_we_o, bram_adr_o, bram_wdata_o,
    input  bram_rdata_i,
    output stat_wb_cnt_o, stat_dma_cnt_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output dma_req_i, dma_we_i, dma_adr_i, dma_dat_i,
    input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    input  bram_en_o, bram_we_o, bram_adr_o, bram_wdata_o,
    output bram_rdata_i,
    input  stat_wb_cnt_o, stat_dma_cnt_o
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one single-port BRAM between the Wishbone slave and the UART DMA engine.
// Optional saturating grant counters are built when ARB_STATS_EN is defined.
module bram_port_arbiter #(
  parameter int ADR_W      = 10,
  parameter int RD_LAT     = 1,
  parameter int WB_ADR_LSB = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  bram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic       OWN_WB   = 1'b0;
  localparam logic       OWN_DMA  = 1'b1;
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  state_t           state_r, state_s;
  logic             last_owner_r, last_owner_s;
  logic             owner_r, owner_s;
  logic             we_r, we_s;
  logic [ADR_W-1:0] adr_r, adr_s;
  logic [31:0]      wdata_r, wdata_s;
  logic [1:0]       cnt_r, cnt_s;
  logic             wb_ack_r, wb_ack_s;
  logic [31:0]      wb_dat_r, wb_dat_s;
  logic             dma_gnt_r, dma_gnt_s;
  logic             dma_rvalid_r, dma_rvalid_s;
  logic [31:0]      dma_rdata_r, dma_rdata_s;
  logic             bram_en_r, bram_en_s;
  logic [3:0]       bram_we_r, bram_we_s;
  logic             wb_req_s;
  logic             grant_wb_s;
  logic             grant_dma_s;
  logic             unused_adr_s;

  assign wb_req_s     = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign unused_adr_s = ^bus.wbs_adr_i;

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Arbitration, next-state and next-value logic for command and output registers
  always_comb begin
    state_s      = state_r;
    last_owner_s = last_owner_r;
    owner_s      = owner_r;
    we_s         = we_r;
    adr_s        = adr_r;
    wdata_s      = wdata_r;
    cnt_s        = cnt_r;
    wb_ack_s     = 1'b0;
    wb_dat_s     = wb_dat_r;
    dma_gnt_s    = 1'b0;
    dma_rvalid_s = 1'b0;
    dma_rdata_s  = dma_rdata_r;
    bram_en_s    = 1'b0;
    bram_we_s    = 4'h0;
    grant_wb_s   = 1'b0;
    grant_dma_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // On contention the requester that did not own the last access wins
        if (wb_req_s && (!bus.dma_req_i || (last_owner_r == OWN_DMA))) begin
          grant_wb_s = 1'b1;
        end else if (bus.dma_req_i) begin
          grant_dma_s = 1'b1;
        end else begin
          grant_wb_s = 1'b0;
        end
        if (grant_wb_s) begin
          state_s      = ST_ACCESS;
          owner_s      = OWN_WB;
          last_owner_s = OWN_WB;
          we_s         = bus.wbs_we_i;
          adr_s        = bus.wbs_adr_i[WB_ADR_LSB +: ADR_W];
          wdata_s      = bus.wbs_dat_i;
          bram_en_s    = 1'b1;
          bram_we_s    = bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
        end else if (grant_dma_s) begin
          state_s      = ST_ACCESS;
          owner_s      = OWN_DMA;
          last_owner_s = OWN_DMA;
          we_s         = bus.dma_we_i;
          adr_s        = bus.dma_adr_i;
          wdata_s      = bus.dma_dat_i;
          bram_en_s    = 1'b1;
          bram_we_s    = bus.dma_we_i ? 4'hF : 4'h0;
          dma_gnt_s    = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (we_r) begin
          state_s  = ST_DONE;
          wb_ack_s = (owner_r == OWN_WB);
          wb_dat_s = (owner_r == OWN_WB) ? 32'h0000_0000 : wb_dat_r;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = LAT_INIT;
        end
      end
      ST_WAIT: begin
        if ((owner_r == OWN_WB) && !bus.wbs_cyc_i) begin
          state_s = ST_IDLE;
          cnt_s   = 2'd0;
        end else if (cnt_r == 2'd1) begin
          state_s = ST_DONE;
          cnt_s   = 2'd0;
          if (owner_r == OWN_WB) begin
            wb_ack_s = 1'b1;
            wb_dat_s = bus.bram_rdata_i;
          end else begin
            dma_rvalid_s = 1'b1;
            dma_rdata_s  = bus.bram_rdata_i;
          end
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Command and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_owner_r <= OWN_DMA;
      owner_r      <= OWN_WB;
      we_r         <= 1'b0;
      adr_r        <= '0;
      wdata_r      <= 32'h0000_0000;
      cnt_r        <= 2'd0;
      wb_ack_r     <= 1'b0;
      wb_dat_r     <= 32'h0000_0000;
      dma_gnt_r    <= 1'b0;
      dma_rvalid_r <= 1'b0;
      dma_rdata_r  <= 32'h0000_0000;
      bram_en_r    <= 1'b0;
      bram_we_r    <= 4'h0;
    end else begin
      last_owner_r <= last_owner_s;
      owner_r      <= owner_s;
      we_r         <= we_s;
      adr_r        <= adr_s;
      wdata_r      <= wdata_s;
      cnt_r        <= cnt_s;
      wb_ack_r     <= wb_ack_s;
      wb_dat_r     <= wb_dat_s;
      dma_gnt_r    <= dma_gnt_s;
      dma_rvalid_r <= dma_rvalid_s;
      dma_rdata_r  <= dma_rdata_s;
      bram_en_r    <= bram_en_s;
      bram_we_r    <= bram_we_s;
    end
  end

  // A Wishbone master dropping cyc in DONE must not see the ack
  assign bus.wbs_ack_o    = wb_ack_r & bus.wbs_cyc_i;
  assign bus.wbs_dat_o    = wb_dat_r;
  assign bus.dma_gnt_o    = dma_gnt_r;
  assign bus.dma_rvalid_o = dma_rvalid_r;
  assign bus.dma_rdata_o  = dma_rdata_r;
  assign bus.bram_en_o    = bram_en_r;
  assign bus.bram_we_o    = bram_we_r;
  assign bus.bram_adr_o   = adr_r;
  assign bus.bram_wdata_o = wdata_r;

`ifdef ARB_STATS_EN
  logic [15:0] stat_wb_r;
  logic [15:0] stat_dma_r;

  // Saturating per-requester grant counters
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stat_wb_r  <= 16'h0000;
      stat_dma_r <= 16'h0000;
    end else begin
      if (grant_wb_s && (stat_wb_r != 16'hFFFF)) begin
        stat_wb_r <= stat_wb_r + 16'd1;
      end
      if (grant_dma_s && (stat_dma_r != 16'hFFFF)) begin
        stat_dma_r <= stat_dma_r + 16'd1;
      end
    end
  end

  assign bus.stat_wb_cnt_o  = stat_wb_r;
  assign bus.stat_dma_cnt_o = stat_dma_r;
`else
  assign bus.stat_wb_cnt_o  = 16'h0000;
  assign bus.stat_dma_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: a word-level memory and round-robin model predict every BRAM
// command, Wishbone ack and DMA read; a negedge monitor compares whatever the DUT presents.
module tb_bram_port_arbiter;
  localparam int RD_LAT = 1;

  typedef struct packed {
    logic [9:0]  adr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        dma;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  cmd_t        cmd_q[$];
  logic [31:0] wb_q[$];
  logic [31:0] dma_q[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] bram_mem [0:1023];
  logic        ref_last_dma;
  int          ref_wb_grants;
  int          ref_dma_grants;

  bram_port_arbiter_if #(.ADR_W(10)) bus ();

  bram_port_arbiter #(.ADR_W(10), .RD_LAT(RD_LAT), .WB_ADR_LSB(2)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  // behavioural BRAM with one cycle of read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) bram_mem[i] <= 32'h0;
    end else if (bus.bram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.bram_we_o[b]) bram_mem[bus.bram_adr_o][8*b +: 8] <= bus.bram_wdata_o[8*b +: 8];
      bus.bram_rdata_i <= bram_mem[bus.bram_adr_o];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // monitor: pops expectations whenever the DUT presents a command or a response
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bram_en_o) begin
        if (cmd_q.size() == 0) flag("unexpected_bram_cmd");
        else begin
          cmd_t c;
          c = cmd_q.pop_front();
          check("bram_adr", 32'(bus.bram_adr_o), 32'(c.adr));
          check("bram_we", 32'(bus.bram_we_o), 32'(c.we));
          if (c.we != 4'h0) check("bram_wdata", bus.bram_wdata_o, c.wdata);
          check("dma_gnt_owner", 32'(bus.dma_gnt_o), 32'(c.dma));
        end
      end else if (bus.dma_gnt_o) flag("stray_dma_gnt");
      if (bus.wbs_ack_o) begin
        if (wb_q.size() == 0) flag("unexpected_wbs_ack");
        else check("wbs_dat", bus.wbs_dat_o, wb_q.pop_front());
      end
      if (bus.dma_rvalid_o) begin
        if (dma_q.size() == 0) flag("unexpected_dma_rvalid");
        else check("dma_rdata", bus.dma_rdata_o, dma_q.pop_front());
      end
    end
  end

  // reference: a WB access as seen by the memory, in grant order
  task automatic model_wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic acked);
    int w;
    w = int'(adr[11:2]);
    cmd_q.push_back('{adr: adr[11:2], we: (we ? sel : 4'h0), wdata: dat, dma: 1'b0});
    if (we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
    if (acked) wb_q.push_back(we ? 32'h0 : ref_mem[w]);
    ref_last_dma = 1'b0;
    ref_wb_grants++;
  endtask

  task automatic model_dma(input logic we, input logic [9:0] adr, input logic [31:0] dat);
    cmd_q.push_back('{adr: adr, we: (we ? 4'hF : 4'h0), wdata: dat, dma: 1'b1});
    if (we) ref_mem[adr] = dat;
    else dma_q.push_back(ref_mem[adr]);
    ref_last_dma = 1'b1;
    ref_dma_grants++;
  endtask

  task automatic wb_drive(input int lat, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    int n = 0;
    logic got = 1'b0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (bus.wbs_ack_o) got = 1'b1;
    end
    if (got) check("wb_ack_latency", 32'(n), 32'(lat));
    else flag("wb_ack_timeout");
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic dma_drive(input int lat, input logic we, input logic [9:0] adr, input logic [31:0] dat);
    int n = 0;
    logic got = 1'b0;
    bus.dma_req_i = 1'b1; bus.dma_we_i = we; bus.dma_adr_i = adr; bus.dma_dat_i = dat;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (bus.dma_gnt_o) got = 1'b1;
    end
    bus.dma_req_i = 1'b0; bus.dma_we_i = 1'b0;
    if (!got) flag("dma_gnt_timeout");
    else begin
      check("dma_gnt_latency", 32'(n), 32'(lat));
      if (we) begin
        repeat (2) begin @(posedge clk); #1; end
      end else begin
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
          @(posedge clk); #1; n++;
          if (bus.dma_rvalid_o) got = 1'b1;
        end
        if (got) check("dma_rvalid_latency", 32'(n), 32'(1 + RD_LAT));
        else flag("dma_rvalid_timeout");
        @(posedge clk); #1;
      end
    end
  endtask

  // mode bit0 = WB request, bit1 = DMA request, both raised in the same cycle
  task automatic do_round(input logic [1:0] mode, input logic wwe, input logic [31:0] wadr,
                          input logic [31:0] wdat, input logic [3:0] wsel,
                          input logic dwe, input logic [9:0] dadr, input logic [31:0] ddat);
    int wb_lat = 0, dma_lat = 0, busy;
    logic wb_first;
    wb_first = mode[0] && (!mode[1] || ref_last_dma);
    if (wb_first) begin
      model_wb(wwe, wadr, wdat, wsel, 1'b1);
      wb_lat = wwe ? 2 : 2 + RD_LAT;
      busy   = wwe ? 3 : 3 + RD_LAT;
      if (mode[1]) begin model_dma(dwe, dadr, ddat); dma_lat = busy + 1; end
    end else begin
      model_dma(dwe, dadr, ddat);
      dma_lat = 1;
      busy    = dwe ? 3 : 3 + RD_LAT;
      if (mode[0]) begin model_wb(wwe, wadr, wdat, wsel, 1'b1); wb_lat = busy + (wwe ? 2 : 2 + RD_LAT); end
    end
    fork
      begin if (mode[0]) wb_drive(wb_lat, wwe, wadr, wdat, wsel); end
      begin if (mode[1]) dma_drive(dma_lat, dwe, dadr, ddat); end
    join
  endtask

  task automatic check_stats(input string tag);
    logic [31:0] exp_wb, exp_dma;
`ifdef ARB_STATS_EN
    exp_wb  = (ref_wb_grants > 65535) ? 32'hFFFF : 32'(ref_wb_grants);
    exp_dma = (ref_dma_grants > 65535) ? 32'hFFFF : 32'(ref_dma_grants);
`else
    exp_wb  = 32'h0;
    exp_dma = 32'h0;
`endif
    check({tag, "_stat_wb"}, 32'(bus.stat_wb_cnt_o), exp_wb);
    check({tag, "_stat_dma"}, 32'(bus.stat_dma_cnt_o), exp_dma);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    bus.dma_req_i = 1'b0; bus.dma_we_i = 1'b0; bus.dma_adr_i = 10'h0; bus.dma_dat_i = 32'h0;
    bus.bram_rdata_i = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_last_dma = 1'b1; ref_wb_grants = 0; ref_dma_grants = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_wbs_ack", 32'(bus.wbs_ack_o), 32'h0);
    check("rst_wbs_dat", bus.wbs_dat_o, 32'h0);
    check("rst_dma_gnt", 32'(bus.dma_gnt_o), 32'h0);
    check("rst_dma_rvalid", 32'(bus.dma_rvalid_o), 32'h0);
    check("rst_dma_rdata", bus.dma_rdata_o, 32'h0);
    check("rst_bram_en", 32'(bus.bram_en_o), 32'h0);
    check("rst_bram_we", 32'(bus.bram_we_o), 32'h0);
    check("rst_bram_adr", 32'(bus.bram_adr_o), 32'h0);
    check("rst_bram_wdata", bus.bram_wdata_o, 32'h0);
    check_stats("rst");

    // simultaneous after reset: WB write first, then DMA reads the fresh word
    do_round(2'b11, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 10'd4, 32'h0);
    do_round(2'b01, 1'b0, 32'h3000_0010, 32'h0, 4'h0, 1'b0, 10'd0, 32'h0);
    // last owner is WB now, so DMA wins this tie
    do_round(2'b11, 1'b1, 32'h3000_0010, 32'h00AA_0000, 4'b0100, 1'b0, 10'd4, 32'h0);
    check_stats("three_two");
    do_round(2'b01, 1'b0, 32'h3000_0010, 32'h0, 4'h0, 1'b0, 10'd0, 32'h0);
    do_round(2'b01, 1'b1, 32'hF000_0010, 32'h1234_5678, 4'h0, 1'b0, 10'd0, 32'h0);
    do_round(2'b10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 10'd9, 32'hCAFE_F00D);
    do_round(2'b01, 1'b0, 32'h0000_0024, 32'h0, 4'h0, 1'b0, 10'd0, 32'h0);

    // WB read abandoned in WAIT: no ack, and DMA is granted straight from the following IDLE
    model_wb(1'b0, 32'h3000_001C, 32'h0, 4'h0, 1'b0);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 32'h3000_001C;
    repeat (2) begin @(posedge clk); #1; end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    model_dma(1'b0, 10'd4, 32'h0);
    dma_drive(2, 1'b0, 10'd4, 32'h0);

    for (int r = 0; r < 250; r++) begin
      logic [31:0] wadr;
      wadr = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      do_round(2'($urandom_range(1, 3)), 1'($urandom()), wadr, $urandom(), 4'($urandom()),
               1'($urandom()), 10'($urandom_range(0, 15)), $urandom());
    end

    repeat (4) begin @(posedge clk); #1; end
    check_stats("final");
    check("cmd_q_left", 32'(cmd_q.size()), 32'h0);
    check("wb_q_left", 32'(wb_q.size()), 32'h0);
    check("dma_q_left", 32'(dma_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
